// File: rtl/udma_stream_src_pkg.sv
// udma_stream_src_pkg
//   Shared definitions for the uDMA stream source: default widths, cfg
//   register indices, CTRL bit positions, FSM state type and small helpers
//   for beat-size arithmetic.
package udma_stream_src_pkg;

    localparam int unsigned DEF_L2_AWIDTH_NOAL  = 19;
    localparam int unsigned DEF_TRANS_SIZE      = 20;
    localparam int unsigned DEF_STREAM_ID_WIDTH = 4;

    localparam logic [4:0] REG_ADDR = 5'd0;
    localparam logic [4:0] REG_SIZE = 5'd1;
    localparam logic [4:0] REG_CFG  = 5'd2;
    localparam logic [4:0] REG_CTRL = 5'd3;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_STOP_BIT  = 1;
    localparam int unsigned CTRL_BUSY_BIT  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        ABORT = 2'd3
    } state_e;

    // Encoding 3 has no legal beat size; it is treated as 32 bit.
    function automatic logic [1:0] eff_datasize(input logic [1:0] ds);
        return (ds == 2'd3) ? 2'd2 : ds;
    endfunction

    function automatic logic [2:0] beat_bytes(input logic [1:0] ds);
        case (ds)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/io_generic_fifo.sv
// io_generic_fifo
//   Power-of-two circular buffer with occupancy count, used by the uDMA core.
//   Ports: clk_i/rstn_i (async active-low reset), clr_i (sync flush),
//   elements_o (occupancy), data_o/valid_o/ready_i (pop side),
//   data_i/valid_i/ready_o (push side). Push and pop may occur together.
module io_generic_fifo #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BUFFER_DEPTH     = 4,
    parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        clr_i,
    output logic [LOG_BUFFER_DEPTH:0]   elements_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    input  logic                        valid_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    output logic                        ready_o
);

    logic [DATA_WIDTH-1:0]       mem [BUFFER_DEPTH];
    logic [LOG_BUFFER_DEPTH-1:0] rd_ptr;
    logic [LOG_BUFFER_DEPTH-1:0] wr_ptr;
    logic [LOG_BUFFER_DEPTH:0]   count;
    logic                        push;
    logic                        pop;

    assign ready_o    = (count != (LOG_BUFFER_DEPTH+1)'(BUFFER_DEPTH));
    assign valid_o    = (count != '0);
    assign data_o     = mem[rd_ptr];
    assign elements_o = count;
    assign push       = valid_i & ready_o;
    assign pop        = valid_o & ready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + LOG_BUFFER_DEPTH'(1);
            if (pop)  rd_ptr <= rd_ptr + LOG_BUFFER_DEPTH'(1);
            case ({push, pop})
                2'b10:   count <= count + (LOG_BUFFER_DEPTH+1)'(1);
                2'b01:   count <= count - (LOG_BUFFER_DEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clr_i) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/udma_stream_src.sv
// udma_stream_src
//   Reads a configured L2 buffer through a uDMA TX channel and emits it as a
//   framed stream (id, sot, eot). Ports: sys_clk_i/rst_i (async active-high),
//   cfg_* peripheral register bus, eot_event_o completion pulse, tx_* L2 read
//   channel, str_* outgoing stream.
module udma_stream_src
    import udma_stream_src_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned L2_AWIDTH_NOAL = DEF_L2_AWIDTH_NOAL,
    parameter int unsigned TRANS_SIZE     = DEF_TRANS_SIZE,
    parameter int unsigned STREAMID_WIDTH = DEF_STREAM_ID_WIDTH,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      sys_clk_i,
    input  logic                      rst_i,
    input  logic [31:0]               cfg_data_i,
    input  logic [4:0]                cfg_addr_i,
    input  logic                      cfg_valid_i,
    input  logic                      cfg_rwn_i,
    output logic                      cfg_ready_o,
    output logic [31:0]               cfg_data_o,
    output logic                      eot_event_o,
    output logic                      tx_req_o,
    output logic [L2_AWIDTH_NOAL-1:0] tx_addr_o,
    output logic [1:0]                tx_datasize_o,
    input  logic                      tx_gnt_i,
    input  logic                      tx_valid_i,
    input  logic [DATA_WIDTH-1:0]     tx_data_i,
    output logic                      tx_ready_o,
    output logic [STREAMID_WIDTH-1:0] str_id_o,
    output logic [DATA_WIDTH-1:0]     str_data_o,
    output logic [1:0]                str_datasize_o,
    output logic                      str_valid_o,
    output logic                      str_sot_o,
    output logic                      str_eot_o,
    input  logic                      str_ready_i
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e                    state;
    logic [L2_AWIDTH_NOAL-1:0] reg_addr, cur_addr;
    logic [TRANS_SIZE-1:0]     reg_size, beats_left, out_left, start_beats;
    logic [1:0]                reg_ds, cur_ds, start_ds;
    logic [STREAMID_WIDTH-1:0] reg_id, cur_id;
    logic [CNT_W-1:0]          inflight, fifo_cnt;
    logic [CNT_W:0]            occupancy;
    logic                      first_beat;
    logic                      cfg_wr, start_req, stop_req;
    logic                      tx_grant, rsp, push, pop, last_hs;
    logic                      fifo_valid, fifo_clr, fifo_pop_ready, rst_n;
    logic                      unused_fifo_ready, unused_cfg;

    assign rst_n      = ~rst_i;
    assign unused_cfg = ^cfg_data_i;

    assign cfg_ready_o = 1'b1;
    assign cfg_wr      = cfg_valid_i & ~cfg_rwn_i;
    assign start_req   = cfg_wr && (cfg_addr_i == REG_CTRL) && cfg_data_i[CTRL_START_BIT];
    assign stop_req    = cfg_wr && (cfg_addr_i == REG_CTRL) && cfg_data_i[CTRL_STOP_BIT];

    assign start_ds = eff_datasize(reg_ds);

    // ceil(size / beat bytes)
    always_comb begin
        case (start_ds)
            2'd1:    start_beats = (reg_size >> 1) + TRANS_SIZE'(reg_size[0]);
            2'd2:    start_beats = (reg_size >> 2) + TRANS_SIZE'(|reg_size[1:0]);
            default: start_beats = reg_size;
        endcase
    end

    always_comb begin
        cfg_data_o = '0;
        case (cfg_addr_i)
            REG_ADDR: cfg_data_o[L2_AWIDTH_NOAL-1:0] = reg_addr;
            REG_SIZE: cfg_data_o[TRANS_SIZE-1:0]     = reg_size;
            REG_CFG: begin
                cfg_data_o[1:0]                = reg_ds;
                cfg_data_o[8 +: STREAMID_WIDTH] = reg_id;
            end
            REG_CTRL: cfg_data_o[CTRL_BUSY_BIT] = (state != IDLE);
            default: cfg_data_o = '0;
        endcase
    end

    // Requests are only issued while a FIFO slot is reserved for the response.
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign tx_req_o  = (state == RUN) && (beats_left != '0) &&
                       (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign tx_grant  = tx_req_o & tx_gnt_i;
    assign tx_ready_o    = (state != IDLE);
    assign tx_addr_o     = cur_addr;
    assign tx_datasize_o = cur_ds;

    assign rsp  = tx_valid_i && (state != IDLE) && (inflight != '0);
    assign push = tx_valid_i && ((state == RUN) || (state == DRAIN));

    assign fifo_clr       = (state == ABORT);
    assign fifo_pop_ready = str_ready_i && (state != ABORT);
    assign str_valid_o    = fifo_valid && (state != ABORT);
    assign pop            = str_valid_o && str_ready_i;
    assign last_hs        = pop && (out_left == TRANS_SIZE'(1));

    assign str_sot_o      = str_valid_o && first_beat;
    assign str_eot_o      = str_valid_o && (out_left == TRANS_SIZE'(1));
    assign str_id_o       = cur_id;
    assign str_datasize_o = cur_ds;

    io_generic_fifo #(
        .DATA_WIDTH   (DATA_WIDTH),
        .BUFFER_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (sys_clk_i),
        .rstn_i     (rst_n),
        .clr_i      (fifo_clr),
        .elements_o (fifo_cnt),
        .data_o     (str_data_o),
        .valid_o    (fifo_valid),
        .ready_i    (fifo_pop_ready),
        .valid_i    (push),
        .data_i     (tx_data_i),
        .ready_o    (unused_fifo_ready)
    );

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            reg_addr    <= '0;
            reg_size    <= '0;
            reg_ds      <= '0;
            reg_id      <= '0;
            cur_addr    <= '0;
            cur_ds      <= '0;
            cur_id      <= '0;
            beats_left  <= '0;
            out_left    <= '0;
            inflight    <= '0;
            first_beat  <= 1'b0;
            eot_event_o <= 1'b0;
        end else begin
            eot_event_o <= 1'b0;

            if (cfg_wr) begin
                case (cfg_addr_i)
                    REG_ADDR: reg_addr <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
                    REG_SIZE: reg_size <= cfg_data_i[TRANS_SIZE-1:0];
                    REG_CFG: begin
                        reg_ds <= cfg_data_i[1:0];
                        reg_id <= cfg_data_i[8 +: STREAMID_WIDTH];
                    end
                    default: ;
                endcase
            end

            case ({tx_grant, rsp})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase

            if (tx_grant) begin
                cur_addr   <= cur_addr + L2_AWIDTH_NOAL'(beat_bytes(cur_ds));
                beats_left <= beats_left - TRANS_SIZE'(1);
            end

            if (pop) begin
                out_left   <= out_left - TRANS_SIZE'(1);
                first_beat <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_req && (start_beats != '0)) begin
                        state      <= RUN;
                        cur_addr   <= reg_addr;
                        cur_ds     <= start_ds;
                        cur_id     <= reg_id;
                        beats_left <= start_beats;
                        out_left   <= start_beats;
                        first_beat <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    // A completing last beat takes priority over a same-cycle stop.
                    if (last_hs) begin
                        state       <= IDLE;
                        eot_event_o <= 1'b1;
                    end else if (stop_req) begin
                        state <= ABORT;
                    end else if ((state == RUN) && tx_grant && (beats_left == TRANS_SIZE'(1))) begin
                        state <= DRAIN;
                    end
                end
                ABORT: begin
                    if ((inflight == '0) && (fifo_cnt == '0)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/udma_stream_src.md
# udma_stream_src

Stream source for the uDMA filter subsystem. It reads a configured buffer from L2 through one uDMA TX channel and emits it as a framed stream of beats with stream ID, start-of-transfer (sot) and end-of-transfer (eot) markers. It is the producer counterpart of the filter's stream input and sits between the uDMA TX channel arbiter and any stream consumer. It is configured through the standard peripheral cfg bus and signals completion through a one-cycle event.

## Interface
- DATA_WIDTH, 32: width of the TX data and the stream data.
- L2_AWIDTH_NOAL, udma_pkg value: width of the L2 byte address.
- TRANS_SIZE, udma_pkg value: width of the byte-count register.
- STREAMID_WIDTH, udma_pkg::STREAM_ID_WIDTH: width of the stream ID.
- FIFO_DEPTH, 4: number of return-data buffer entries; must be a power of 2 and ≥2.
- sys_clk_i  in  1  single clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cfg_data_i  in  32  register write data.
- cfg_addr_i  in  5  register word index.
- cfg_valid_i  in  1  register access strobe.
- cfg_rwn_i  in  1  1 = read, 0 = write.
- cfg_ready_o  out  1  tied to 1.
- cfg_data_o  out  32  read data, combinational from cfg_addr_i.
- eot_event_o  out  1  one-cycle pulse when a transfer completes normally.
- tx_req_o  out  1  L2 read request.
- tx_addr_o  out  L2_AWIDTH_NOAL  request byte address.
- tx_datasize_o  out  2  request size: 0 = 8 bit, 1 = 16 bit, 2 = 32 bit.
- tx_gnt_i  in  1  request accepted.
- tx_valid_i  in  1  read data valid.
- tx_data_i  in  DATA_WIDTH  read data, LSB-aligned.
- tx_ready_o  out  1  read data accepted.
- str_id_o  out  STREAMID_WIDTH  stream ID, constant for the whole transfer.
- str_data_o, str_datasize_o, str_valid_o, str_sot_o, str_eot_o  out  DATA_WIDTH/2/1/1/1  outgoing stream.
- str_ready_i  in  1  stream consumer ready.

## Operation
- Registers:
  - 0 ADDR[L2_AWIDTH_NOAL-1:0]: L2 start address.
  - 1 SIZE[TRANS_SIZE-1:0]: transfer length in bytes.
  - 2 CFG: [1:0] datasize, [8+:STREAMID_WIDTH] stream ID.
  - 3 CTRL: write bit0 = start, write bit1 = stop; read bit0 = busy.
  - All registers reset to 0. Unmapped addresses read 0 and ignore writes.
- Register writes while busy are stored but apply only at the next start.
- Start while busy is ignored. Start with SIZE = 0 is ignored: no beats, no event.
- Beat size is 1<<datasize bytes. Beat count is ceil(SIZE / beat size).
- On start, the block latches ADDR, beat count, datasize and ID into working registers.
- FSM:
  - IDLE → RUN on a valid start.
  - RUN → DRAIN after the last request is granted.
  - DRAIN → IDLE after the last stream beat handshakes.
  - RUN/DRAIN → ABORT on stop.
  - ABORT → IDLE when the in-flight count = 0 and the FIFO is flushed.
- Credit rule: tx_req_o = RUN && beats_left > 0 && (inflight + fifo_count) < FIFO_DEPTH. The FIFO therefore never overflows.
- tx_req_o && tx_gnt_i: address += beat size, beats_left −1, inflight +1.
- tx_ready_o = 1 outside IDLE. tx_valid_i pushes tx_data_i into the FIFO and decrements inflight; in ABORT the data is discarded instead.
- Stream outputs:
  - str_valid_o = FIFO not empty and state is not ABORT; str_data_o = FIFO head.
  - str_sot_o is high on the first beat of the transfer.
  - str_eot_o is high on the last beat.
  - A single-beat transfer has sot and eot high together.
- str_datasize_o = latched datasize. Data is passed through unmodified.
- Address arithmetic wraps modulo 2^L2_AWIDTH_NOAL.
- Stop in IDLE has no effect. Stop produces no eot beat and no eot_event_o.

## Timing
- After reset, all outputs are 0 except cfg_ready_o = 1.
- Reset asserted mid-transfer returns the block to IDLE immediately. In-flight TX responses arriving after reset are ignored (tx_ready_o = 0 in IDLE).
- A start written in cycle N gives busy = 1 and tx_req_o = 1 in cycle N+1.
- tx_addr_o and tx_datasize_o are stable while tx_req_o && !tx_gnt_i.
- FIFO latency is 1: data pushed in cycle N can be presented in cycle N+1.
- Simultaneous push and pop is supported at any occupancy.
- While str_valid_o && !str_ready_i, all str_* outputs hold stable.
- Last-beat handshake in cycle N:
  - busy = 0 and state = IDLE in cycle N+1.
  - eot_event_o high only in cycle N+1.
  - A new start is accepted from cycle N+1.
- Sustained throughput is 1 beat per cycle when gnt, valid and str_ready are continuously high.

## Structure
- udma_stream_src_pkg holds:
  - the register indices REG_ADDR = 0, REG_SIZE = 1, REG_CFG = 2, REG_CTRL = 3;
  - the CTRL bit positions;
  - the state enum {IDLE, RUN, DRAIN, ABORT}.
- The one sub-module is io_generic_fifo (the existing uDMA core FIFO), instantiated with DATA_WIDTH and FIFO_DEPTH. It buffers only data; sot/eot are derived from the beat counter at the FIFO output.

## Test plan
- ADDR = 0x100, SIZE = 16, datasize 2, ID 3, gnt/valid/ready always 1 → requests to 0x100/104/108/10C; 4 beats with ID 3; sot on beat 0, eot on beat 3; one eot_event_o pulse.
- SIZE = 5, datasize 1 → 3 requests with stride 2; eot on the third beat.
- SIZE = 1, datasize 0 → a single beat with sot = eot = 1.
- str_ready_i held 0 for 20 cycles → exactly FIFO_DEPTH requests outstanding, then tx_req_o = 0; str_* stable; no data loss after release.
- Stop after 2 of 8 beats with 2 reads in flight → both late responses are discarded; no eot beat, no event; busy drops; the next start streams correctly.
- ADDR = 2^L2_AWIDTH_NOAL − 4, SIZE = 8 → second request address is 0; start while busy is ignored; SIZE = 0 start produces no activity.
